// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI constants and transmit state encoding
package spi_pkg;
    localparam logic CPOL           = 1'b0;
    localparam logic CPHA           = 1'b0;
    localparam int   SPI_FRAME_BITS = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LOAD,
        TX_SHIFT
    } spi_tx_state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchroniser with rise/fall pulses
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;
endmodule

// File: rtl/spi_peripheral_tx.sv
// rtl/spi_peripheral_tx.sv - SPI mode-0 peripheral transmitter with one-byte holding buffer
module spi_peripheral_tx
    import spi_pkg::*;
#(
    parameter logic [7:0] DUMMY_BYTE  = 8'hFF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCLK,
    input  logic       spi_cs_n,
    output logic       CIPO,
    output logic       cipo_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       byte_sent,
    output logic       underrun,
    output logic       tx_abort
);
    localparam logic [3:0] FRAME_CNT = 4'(SPI_FRAME_BITS);

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_n_level, cs_n_rise, cs_n_fall;
    logic unused_sync;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (SCLK ^ CPOL),
        .level(sclk_level),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (spi_cs_n),
        .level(cs_n_level),
        .rise (cs_n_rise),
        .fall (cs_n_fall)
    );

    assign unused_sync = sclk_level ^ cs_n_rise ^ cs_n_fall;

    spi_tx_state_t state_q, state_d;
    logic [7:0] shift_q, shift_d, hold_data_q, hold_data_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic       sr_real_q, sr_real_d, hold_full_q, hold_full_d;
    logic       cipo_q, cipo_d, oe_q, oe_d;
    logic       byte_sent_q, byte_sent_d, underrun_q, underrun_d, abort_q, abort_d;
    logic       do_load;

    assign tx_ready = ~hold_full_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        sr_real_d   = sr_real_q;
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        byte_sent_d = 1'b0;
        underrun_d  = 1'b0;
        abort_d     = 1'b0;
        do_load     = 1'b0;

        if (tx_valid && tx_ready) begin
            hold_data_d = tx_data;
            hold_full_d = 1'b1;
        end

        // CS release overrides any SCLK activity seen in the same cycle
        if (state_q != TX_IDLE && cs_n_level) begin
            state_d   = TX_IDLE;
            bit_cnt_d = 4'd0;
            abort_d   = sr_real_q;
            sr_real_d = 1'b0;
        end else begin
            case (state_q)
                TX_IDLE: if (!cs_n_level) state_d = TX_LOAD;
                TX_LOAD: begin
                    do_load = 1'b1;
                    state_d = TX_SHIFT;
                end
                TX_SHIFT: begin
                    if (sclk_rise) begin
                        if (bit_cnt_q != FRAME_CNT) begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                            if (bit_cnt_q == FRAME_CNT - 4'd1 && sr_real_q) begin
                                byte_sent_d = 1'b1;
                                sr_real_d   = 1'b0;
                            end
                        end
                    end else if (sclk_fall) begin
                        if (bit_cnt_q == FRAME_CNT) do_load = 1'b1;
                        else if (bit_cnt_q != 4'd0) shift_d = {shift_q[6:0], 1'b0};
                    end
                end
                default: state_d = TX_IDLE;
            endcase
        end

        // A byte accepted this cycle is not visible here: loads use hold_full_q only
        if (do_load) begin
            bit_cnt_d = 4'd0;
            if (hold_full_q) begin
                shift_d     = hold_data_q;
                hold_full_d = 1'b0;
                sr_real_d   = 1'b1;
            end else begin
                shift_d    = DUMMY_BYTE;
                sr_real_d  = 1'b0;
                underrun_d = 1'b1;
            end
        end

        cipo_d = (state_d == TX_SHIFT) & shift_d[7];
        oe_d   = (state_d != TX_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= TX_IDLE;
            shift_q     <= 8'd0;
            bit_cnt_q   <= 4'd0;
            sr_real_q   <= 1'b0;
            hold_full_q <= 1'b0;
            hold_data_q <= 8'd0;
            cipo_q      <= 1'b0;
            oe_q        <= 1'b0;
            byte_sent_q <= 1'b0;
            underrun_q  <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            sr_real_q   <= sr_real_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            cipo_q      <= cipo_d;
            oe_q        <= oe_d;
            byte_sent_q <= byte_sent_d;
            underrun_q  <= underrun_d;
            abort_q     <= abort_d;
        end
    end

    assign CIPO      = cipo_q;
    assign cipo_oe   = oe_q;
    assign tx_busy   = oe_q;
    assign byte_sent = byte_sent_q;
    assign underrun  = underrun_q;
    assign tx_abort  = abort_q;
endmodule

// File: tb/tb_spi_peripheral_tx.sv
// tb/tb_spi_peripheral_tx.sv - randomized model-checked bench for spi_peripheral_tx
module tb_spi_peripheral_tx;
    localparam logic [7:0] DUMMY = 8'hFF;

    logic       clk = 1'b0;
    logic       rst, SCLK, spi_cs_n, CIPO, cipo_oe;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready, tx_busy, byte_sent, underrun, tx_abort;

    int n_checks = 0, n_err = 0;
    int obs_bs = 0, obs_ub = 0, obs_ab = 0;
    int exp_bs = 0, exp_ub = 0, exp_ab = 0;
    logic [7:0] hold_q[$];
    logic [7:0] rx_log[$];
    bit   chk_en = 1'b0;
    logic exp_cipo = 1'b0, exp_oe = 1'b0;

    always #5 clk = ~clk;

    spi_peripheral_tx dut (
        .clk      (clk),
        .rst      (rst),
        .SCLK     (SCLK),
        .spi_cs_n (spi_cs_n),
        .CIPO     (CIPO),
        .cipo_oe  (cipo_oe),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_busy  (tx_busy),
        .byte_sent(byte_sent),
        .underrun (underrun),
        .tx_abort (tx_abort)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model's expected pin state
    always @(negedge clk) begin
        if (!rst) begin
            if (byte_sent) obs_bs++;
            if (underrun)  obs_ub++;
            if (tx_abort)  obs_ab++;
        end
        if (chk_en) begin
            check("cipo", int'(CIPO), int'(exp_cipo));
            check("cipo_oe", int'(cipo_oe), int'(exp_oe));
            check("tx_busy", int'(tx_busy), int'(exp_oe));
            check("tx_ready", int'(tx_ready), int'(hold_q.size() == 0));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_load(output logic [7:0] b, output bit r);
        if (hold_q.size() > 0) begin
            b = hold_q.pop_front();
            r = 1'b1;
        end else begin
            b = DUMMY;
            r = 1'b0;
            exp_ub++;
        end
    endtask

    task automatic push(input logic [7:0] b);
        check("push_ready", int'(tx_ready), int'(hold_q.size() == 0));
        tx_data  = b;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        hold_q.push_back(b);
    endtask

    task automatic do_frame(input int nbytes, input int last_bits, input bit tail_fall,
                            input bit mid_push, input logic [7:0] mid_byte);
        logic [7:0] cur, rx;
        bit real_b, pending;
        chk_en = 1'b0;
        spi_cs_n = 1'b0;
        rx_log.delete();
        model_load(cur, real_b);
        pending = real_b;
        tick(7);
        exp_cipo = cur[7];
        exp_oe   = 1'b1;
        chk_en   = 1'b1;
        tick(1);
        for (int b = 0; b < nbytes; b++) begin
            int nb;
            nb = (b == nbytes - 1) ? last_bits : 8;
            rx = 8'd0;
            for (int i = 0; i < nb; i++) begin
                SCLK = 1'b1;
                rx = {rx[6:0], CIPO};
                if (mid_push && b == 0 && i == 3 && hold_q.size() == 0) begin
                    push(mid_byte);
                    tick(7);
                end else begin
                    tick(8);
                end
                if (i == 7) begin
                    if (pending) exp_bs++;
                    pending = 1'b0;
                    check("rx_byte", int'(rx), int'(cur));
                    rx_log.push_back(rx);
                end
                if (b == nbytes - 1 && i == nb - 1 && !tail_fall) break;
                chk_en = 1'b0;
                SCLK = 1'b0;
                if (i == 7) begin
                    model_load(cur, real_b);
                    pending  = real_b;
                    exp_cipo = cur[7];
                end else begin
                    exp_cipo = cur[6 - i];
                end
                tick(6);
                chk_en = 1'b1;
                tick(2);
            end
        end
        chk_en = 1'b0;
        spi_cs_n = 1'b1;
        if (pending) exp_ab++;
        tick(8);
        SCLK = 1'b0;
        exp_cipo = 1'b0;
        exp_oe   = 1'b0;
        chk_en   = 1'b1;
        tick(4);
        check("byte_sent_count", obs_bs, exp_bs);
        check("underrun_count", obs_ub, exp_ub);
        check("abort_count", obs_ab, exp_ab);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base_ub;
        rst = 1'b1; SCLK = 1'b0; spi_cs_n = 1'b1; tx_valid = 1'b0; tx_data = 8'd0;
        tick(3);
        check("rst_cipo", int'(CIPO), 0);
        check("rst_oe", int'(cipo_oe), 0);
        check("rst_busy", int'(tx_busy), 0);
        check("rst_ready", int'(tx_ready), 1);
        check("rst_pulses", int'({byte_sent, underrun, tx_abort}), 0);
        rst = 1'b0;
        tick(2);
        chk_en = 1'b1;

        // single byte
        push(8'hA5);
        do_frame(1, 8, 1'b0, 1'b0, 8'h00);
        check("single_rx", int'(rx_log[0]), 'hA5);
        check("single_bs", obs_bs, 1);

        // back-to-back with mid-frame push
        push(8'h3C);
        do_frame(2, 8, 1'b0, 1'b1, 8'hC3);
        check("b2b_rx0", int'(rx_log[0]), 'h3C);
        check("b2b_rx1", int'(rx_log[1]), 'hC3);
        check("b2b_bs", obs_bs, 3);
        check("b2b_ub", obs_ub, 0);

        // underrun
        do_frame(1, 8, 1'b0, 1'b0, 8'h00);
        check("ur_rx", int'(rx_log[0]), 'hFF);
        check("ur_ub", obs_ub, 1);
        check("ur_bs", obs_bs, 3);

        // abort after 3 rises, then a fresh byte
        push(8'h81);
        do_frame(1, 3, 1'b0, 1'b0, 8'h00);
        check("abort_cnt", obs_ab, 1);
        push(8'h42);
        do_frame(1, 8, 1'b0, 1'b0, 8'h00);
        check("abort_next_rx", int'(rx_log[0]), 'h42);

        // backpressure
        push(8'h11);
        tx_data  = 8'h22;
        tx_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("bp_ready_low", int'(tx_ready), 0);
            tick(1);
        end
        fork
            do_frame(1, 8, 1'b0, 1'b0, 8'h00);
            begin
                bit got;
                got = 1'b0;
                for (int k = 0; k < 60 && !got; k++) begin
                    @(negedge clk);
                    if (tx_ready) begin
                        @(posedge clk);
                        #1;
                        tx_valid = 1'b0;
                        hold_q.push_back(8'h22);
                        got = 1'b1;
                    end
                end
                check("bp_accept", int'(got), 1);
            end
        join
        tx_valid = 1'b0;
        check("bp_rx0", int'(rx_log[0]), 'h11);
        do_frame(1, 8, 1'b0, 1'b0, 8'h00);
        check("bp_rx1", int'(rx_log[0]), 'h22);

        // reset mid-frame
        push(8'hF0);
        chk_en = 1'b0;
        spi_cs_n = 1'b0;
        void'(hold_q.pop_front());
        tick(8);
        repeat (4) begin
            SCLK = 1'b1; tick(8);
            SCLK = 1'b0; tick(8);
        end
        rst = 1'b1;
        #1;
        check("mid_rst_cipo", int'(CIPO), 0);
        check("mid_rst_oe", int'(cipo_oe), 0);
        check("mid_rst_busy", int'(tx_busy), 0);
        check("mid_rst_ready", int'(tx_ready), 1);
        check("mid_rst_pulses", int'({byte_sent, underrun, tx_abort}), 0);
        spi_cs_n = 1'b1;
        tick(3);
        rst = 1'b0;
        hold_q.delete();
        tick(2);
        exp_cipo = 1'b0; exp_oe = 1'b0; chk_en = 1'b1;
        base_ub = obs_ub;
        do_frame(1, 8, 1'b0, 1'b0, 8'h00);
        check("post_rst_rx", int'(rx_log[0]), 'hFF);
        check("post_rst_ub", obs_ub, base_ub + 1);

        // randomized frames
        for (int it = 0; it < 40; it++) begin
            int nbytes, last;
            bit tail, mp;
            if (hold_q.size() == 0 && $urandom_range(0, 1) == 1) push(8'($urandom));
            nbytes = int'($urandom_range(1, 3));
            last   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 8;
            tail   = ($urandom_range(0, 1) == 1);
            mp     = ($urandom_range(0, 1) == 1);
            do_frame(nbytes, last, tail, mp, 8'($urandom));
            tick(int'($urandom_range(1, 5)));
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/spi_peripheral_tx.md
Name: spi_peripheral_tx

Overview:
SPI mode-0 (CPOL=0, CPHA=0) peripheral transmitter that drives CIPO, returning classification results and status bytes to the external SPI controller. It accepts bytes from the core over a valid/ready handshake and holds them in a one-entry buffer. It serialises each byte MSB-first whenever the controller clocks a frame. It shares SCLK and spi_cs_n with the receive path and runs entirely in the clk domain, oversampling SCLK; clk must be at least 8x SCLK.

Parameters:
DUMMY_BYTE, 8'hFF, byte shifted out when the controller clocks but no data is buffered (underrun).
SYNC_STAGES, 2, flop stages on SCLK and spi_cs_n before edge detection; legal values 2..3.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
SCLK  in  1  SPI clock from controller (async)
spi_cs_n  in  1  chip select, active low (async)
CIPO  out  1  serial data to controller
cipo_oe  out  1  output enable for the CIPO pad tri-state
tx_data  in  8  byte to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  holding buffer empty; the byte is accepted on tx_valid && tx_ready
tx_busy  out  1  frame in progress (state != TX_IDLE)
byte_sent  out  1  1-cycle pulse: a buffered (non-dummy) byte has been fully shifted out
underrun  out  1  1-cycle pulse: DUMMY_BYTE loaded into the shift register
tx_abort  out  1  1-cycle pulse: CS deasserted while a non-dummy byte was loaded and not fully sent

Behaviour:
- Reset (async, rst=1): state TX_IDLE; CIPO=0; cipo_oe=0; tx_busy=0; all pulses 0; hold_full=0, so tx_ready=1; shift_reg=0; bit_cnt=0; sr_real=0.
- Synchronisers: SCLK and spi_cs_n each pass through SYNC_STAGES flops. Edges are detected on the last two synced samples. Response latency is SYNC_STAGES+1 clk cycles from a pin edge.
- Holding buffer: tx_ready = ~hold_full (combinational).
  - On accept: hold_data <= tx_data; hold_full <= 1.
  - The buffer contents survive CS deassertion and frame boundaries.
  - A load decision uses the registered hold_full only. A byte accepted in the same cycle as a load stays in the buffer for the next load; no bypass.
- Load operation (shared by TX_LOAD and byte boundary):
  - If hold_full: shift_reg <= hold_data; hold_full <= 0; sr_real <= 1.
  - Else: shift_reg <= DUMMY_BYTE; sr_real <= 0; underrun pulses.
  - In both cases bit_cnt <= 0.
- States:
  - TX_IDLE: when synced CS is low -> TX_LOAD.
  - TX_LOAD (1 cycle): perform load -> TX_SHIFT. CIPO shows shift_reg[7] from the next cycle, before the first SCLK rise; the controller must allow at least SYNC_STAGES+3 clk cycles of CS setup.
  - TX_SHIFT:
    - SCLK rising: bit_cnt <= bit_cnt+1. When bit_cnt==7 and sr_real: byte_sent pulses and sr_real <= 0.
    - SCLK falling with bit_cnt==8: perform load (back-to-back bytes, no gap).
    - SCLK falling with bit_cnt in 1..7: shift_reg <= {shift_reg[6:0],1'b0}.
    - SCLK falling with bit_cnt==0: no action.
  - Any state, synced CS goes high: -> TX_IDLE next cycle. If sr_real=1, tx_abort pulses; the partial byte is discarded, not re-queued. bit_cnt <= 0.
- Outputs:
  - CIPO = shift_reg[7] in TX_SHIFT, else 0.
  - cipo_oe = 1 in TX_LOAD/TX_SHIFT.
  - tx_busy = (state != TX_IDLE).
  - All outputs are registered except tx_ready.
- Width rules: bit_cnt is 4 bits and saturates at 8. Extra rising edges beyond 8 without a falling edge are ignored.
- CS rising and an SCLK edge detected in the same cycle: CS wins; no shift, no byte_sent.

Decomposition:
- Package spi_pkg holds CPOL, CPHA, SPI_FRAME_BITS=8, and typedef enum spi_tx_state_t {TX_IDLE, TX_LOAD, TX_SHIFT}. The receive path reuses the package constants.
- One sub-module, spi_sync_edge: SYNC_STAGES synchroniser plus rise/fall pulse outputs. Instantiate it for SCLK and for spi_cs_n; it is reusable by the receiver.

Test Plan:
- Single byte: push 0xA5, then CS low and 8 mode-0 SCLK cycles (SCLK = clk/16) -> controller samples 1,0,1,0,0,1,0,1; byte_sent pulses once after the 8th rise; tx_ready returns to 1 at TX_LOAD.
- Back-to-back: push 0x3C, then push 0xC3 while 0x3C is shifting; 16 SCLK in one CS frame -> 0x3C then 0xC3 received, two byte_sent pulses, no underrun.
- Underrun: CS low with empty buffer, 8 SCLK -> 0xFF received; underrun pulses at TX_LOAD; no byte_sent.
- Abort: push 0x81, CS high after 3 SCLK rises -> tx_abort pulses once, CIPO=0, cipo_oe=0. Push 0x42 (tx_ready=1), new frame -> 0x42 received, not 0x81.
- Backpressure: push 0x11 with CS high, then hold tx_valid with 0x22 -> tx_ready=0 and 0x22 not accepted until the 0x11 load; frame delivers 0x11, and a second byte delivers 0x22.
- Reset mid-frame: assert rst after 4 bits of 0xF0 -> all outputs at reset values the same cycle; after release, a frame with empty buffer yields 0xFF plus underrun.
